// File: rtl/fft_seq_ctrl.sv
// Control sequencer for an N-point radix-2 FFT datapath.
// Drives ROM reads, the S2P load, one-hot butterfly stages and done.
module fft_seq_ctrl #(
  parameter int LOG2N   = 3,
  parameter int FRAME_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     bitrev,
  output logic                     rd_en,
  output logic [FRAME_W+LOG2N-1:0] rd_addr,
  output logic                     en_s2p,
  output logic [LOG2N-1:0]         s2p_idx,
  output logic [LOG2N-1:0]         en_stage,
  output logic                     busy,
  output logic                     done,
  output logic [FRAME_W-1:0]       frame_idx,
  output logic                     start_drop
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    STAGE,
    DONE
  } state_t;

  localparam logic [LOG2N-1:0] LAST_K   = {LOG2N{1'b1}};
  localparam logic [LOG2N-1:0] LAST_STG = LOG2N'(LOG2N - 1);
  localparam logic [LOG2N-1:0] STG0     = LOG2N'(1);
  localparam logic [LOG2N-1:0] K0       = '0;

  state_t             state;
  logic [LOG2N-1:0]   cnt;
  logic               brev;
  logic [FRAME_W-1:0] frame_nxt;

  function automatic logic [LOG2N-1:0] rev_bits(
    input logic [LOG2N-1:0] v
  );
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

  function automatic logic [FRAME_W+LOG2N-1:0] mk_addr(
    input logic [FRAME_W-1:0] f,
    input logic [LOG2N-1:0]   k,
    input logic               br
  );
    return {f, br ? rev_bits(k) : k};
  endfunction

  // Frame index seen by a frame launched from the current state.
  always_comb begin
    frame_nxt = frame_idx;
    if (state == DONE) begin
      frame_nxt = frame_idx + 1'b1;
    end
  end

  // Sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      brev       <= 1'b0;
      frame_idx  <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      en_s2p     <= 1'b0;
      s2p_idx    <= '0;
      en_stage   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      start_drop <= 1'b0;
    end else begin
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      en_s2p     <= (state == LOAD);
      s2p_idx    <= (state == LOAD) ? cnt : '0;
      en_stage   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      start_drop <= 1'b0;
      frame_idx  <= frame_nxt;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= LOAD;
            cnt     <= '0;
            brev    <= bitrev;
            rd_en   <= 1'b1;
            rd_addr <= mk_addr(frame_nxt, K0, bitrev);
            busy    <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          start_drop <= start;
          busy       <= 1'b1;
          if (cnt == LAST_K) begin
            state <= DRAIN;
            cnt   <= '0;
          end else begin
            cnt     <= cnt + 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= mk_addr(frame_idx, cnt + 1'b1, brev);
          end
        end
        DRAIN: begin
          start_drop <= start;
          busy       <= 1'b1;
          state      <= STAGE;
          cnt        <= '0;
          en_stage   <= STG0;
        end
        STAGE: begin
          start_drop <= start;
          if (cnt == LAST_STG) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            cnt      <= cnt + 1'b1;
            en_stage <= en_stage << 1;
            busy     <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl (N=8 main DUT, N=16 timing DUT).
// Stimulus plans expected per-cycle outputs; a monitor pops and compares.
module tb_fft_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       bitrev;
  logic       rd_en;
  logic [4:0] rd_addr;
  logic       en_s2p;
  logic [2:0] s2p_idx;
  logic [2:0] en_stage;
  logic       busy;
  logic       done;
  logic [1:0] frame_idx;
  logic       start_drop;

  logic       b_start;
  logic       b_rd_en;
  logic [5:0] b_rd_addr;
  logic       b_en_s2p;
  logic [3:0] b_s2p_idx;
  logic [3:0] b_en_stage;
  logic       b_busy;
  logic       b_done;
  logic [1:0] b_frame_idx;
  logic       b_start_drop;

  always #5 clk = ~clk;

  fft_seq_ctrl #(.LOG2N(3), .FRAME_W(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .bitrev(bitrev), .rd_en(rd_en), .rd_addr(rd_addr),
    .en_s2p(en_s2p), .s2p_idx(s2p_idx),
    .en_stage(en_stage), .busy(busy), .done(done),
    .frame_idx(frame_idx), .start_drop(start_drop)
  );

  fft_seq_ctrl #(.LOG2N(4), .FRAME_W(2)) dut16 (
    .clk(clk), .reset(reset), .start(b_start),
    .bitrev(1'b0), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .en_s2p(b_en_s2p), .s2p_idx(b_s2p_idx),
    .en_stage(b_en_stage), .busy(b_busy), .done(b_done),
    .frame_idx(b_frame_idx), .start_drop(b_start_drop)
  );

  typedef struct {
    int         cyc;
    logic       rd_en;
    logic [4:0] addr;
    logic       en_s2p;
    logic [2:0] idx;
    logic [2:0] stage;
    logic       done;
    logic       drop;
    logic       busy;
    logic [1:0] fidx;
  } rec_t;

  rec_t plan[int];
  rec_t exp_q[$];
  int   addr_log[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [17:0] pk(input rec_t r);
    return {r.rd_en, r.addr, r.en_s2p, r.idx, r.stage,
            r.done, r.drop, r.busy, r.fidx};
  endfunction

  function automatic logic [2:0] rev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  function automatic void plan_frame(input int t0, input int f,
                                     input bit br, input int upto);
    rec_t r;
    logic [1:0] fb;
    logic [2:0] k;
    fb = f[1:0];
    for (int j = 1; j <= upto; j++) begin
      r = '{default: 0};
      r.cyc  = t0 + j;
      r.fidx = fb;
      r.busy = (j != 13);
      if (j <= 8) begin
        k = 3'(j - 1);
        r.rd_en = 1'b1;
        r.addr  = {fb, br ? rev3(k) : k};
      end
      if (j >= 2 && j <= 9) begin
        r.en_s2p = 1'b1;
        r.idx    = 3'(j - 2);
      end
      if (j >= 10 && j <= 12) r.stage = 3'(1 << (j - 10));
      if (j == 13) r.done = 1'b1;
      plan[r.cyc] = r;
    end
  endfunction

  function automatic void commit();
    foreach (plan[c]) exp_q.push_back(plan[c]);
    plan.delete();
  endfunction

  // Monitor: every cycle with activity pops one expected record.
  always @(negedge clk) begin
    rec_t o;
    rec_t e;
    if (rd_en || en_s2p || en_stage != 0 || done || start_drop) begin
      o = '{cyc + 1, rd_en, rd_addr, en_s2p, s2p_idx, en_stage,
            done, start_drop, busy, frame_idx};
      if (rd_en) addr_log.push_back(int'(rd_addr));
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_out t=%0d got=%h required=none",
                 o.cyc, pk(o));
      end else begin
        e = exp_q.pop_front();
        if (e.cyc == o.cyc && pk(e) == pk(o)) n_pass++;
        else $display("FAIL sb t=%0d/%0d got=%h required=%h",
                      o.cyc, e.cyc, pk(o), pk(e));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string nm, input int got, input int req);
    n_chk++;
    if (got == req) n_pass++;
    else $display("FAIL %s got=%0d required=%0d", nm, got, req);
  endtask

  task automatic go(input bit br, output int t0);
    start  = 1'b1;
    bitrev = br;
    t0     = cyc + 1;
    tick(1);
    start  = 1'b0;
    bitrev = 1'b0;
  endtask

  task automatic check_quiet(input string nm);
    check(nm, int'({rd_en, rd_addr, en_s2p, s2p_idx, en_stage,
                    busy, done, frame_idx, start_drop}), 0);
  endtask

  int t0;
  int exp_addr[8] = '{8, 12, 10, 14, 9, 13, 11, 15};
  int rd_cnt;
  int stg_cnt;
  int done_at;

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    bitrev  = 1'b0;
    b_start = 1'b0;
    tick(3);
    check_quiet("reset_state");
    reset = 1'b0;
    tick(2);

    // Natural-order frame 0.
    plan_frame(cyc + 1, 0, 1'b0, 13);
    commit();
    go(1'b0, t0);
    tick(13);
    check("frame_idx_after_f0", int'(frame_idx), 1);
    check("busy_idle", int'(busy), 0);

    // Bit-reversed frame 1.
    addr_log.delete();
    plan_frame(cyc + 1, 1, 1'b1, 13);
    commit();
    go(1'b1, t0);
    tick(14);
    check("bitrev_len", addr_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < addr_log.size()) check("bitrev_addr", addr_log[i], exp_addr[i]);
    end
    check("frame_idx_after_f1", int'(frame_idx), 2);

    // Back-to-back: five frames, start on each DONE.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    check("frame_idx_reset", int'(frame_idx), 0);
    for (int k = 0; k < 5; k++) begin
      plan_frame(cyc + 1 + 13 * k, k % 4, 1'b0, 13);
    end
    commit();
    go(1'b0, t0);
    for (int k = 1; k < 5; k++) begin
      tick(12);
      start = 1'b1;
      tick(1);
      start = 1'b0;
    end
    tick(13);
    check("frame_idx_b2b", int'(frame_idx), 1);
    tick(2);

    // Start while busy is dropped.
    plan_frame(cyc + 1, 1, 1'b0, 13);
    plan[cyc + 7].drop = 1'b1;
    commit();
    go(1'b0, t0);
    tick(4);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(24);
    check("frame_idx_drop", int'(frame_idx), 2);

    // Reset during stage 0 aborts; start in reset cycle discarded.
    plan_frame(cyc + 1, 2, 1'b0, 10);
    commit();
    go(1'b0, t0);
    tick(9);
    reset = 1'b1;
    start = 1'b1;
    tick(1);
    check_quiet("reset_abort");
    tick(1);
    reset = 1'b0;
    start = 1'b0;
    tick(3);
    check_quiet("reset_no_start");
    plan_frame(cyc + 1, 0, 1'b0, 13);
    commit();
    go(1'b0, t0);
    tick(13);
    check("frame_idx_replay", int'(frame_idx), 1);

    // N=16 timing.
    rd_cnt  = 0;
    stg_cnt = 0;
    done_at = -1;
    b_start = 1'b1;
    t0      = cyc + 1;
    tick(1);
    b_start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (b_rd_en) rd_cnt++;
      if (b_en_stage != 0) stg_cnt++;
      if (b_done && done_at < 0) done_at = cyc + 1 - t0;
      tick(1);
    end
    check("n16_load_cycles", rd_cnt, 16);
    check("n16_stage_cycles", stg_cnt, 4);
    check("n16_done_lat", done_at, 22);

    check("sb_leftover", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
